// File: rtl/instr_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// instr_ptr_ctrl
//
// Sequencer for the per-core instruction pointer. It takes decoded flow-control
// requests (jump, call, return, halt) and stalls, and drives the enable,
// load_enable and load_val inputs of instr_ptr. It also holds a hardware
// call/return stack and reports start/halt/error status.
//
// Parameters
//   WIDTH        instruction address width (must match instr_ptr)
//   STACK_DEPTH  number of call-stack entries (>= 1)
//
// Ports
//   clk              core clock
//   reset_n          asynchronous reset, active low
//   start            one-cycle pulse, begin execution at start_addr
//                    (honoured only in IDLE/HALT/ERR)
//   start_addr       program entry address
//   stall            hold the current instruction
//   halt_req         decoded halt/done instruction
//   jump_req         decoded conditional jump
//   jump_cond        jump condition (1 = taken)
//   call_req         decoded call, target on jump_addr
//   ret_req          decoded return
//   jump_addr        jump/call target
//   ptr_in           current fetch address from instr_ptr
//   ptr_enable       -> instr_ptr enable       (combinational)
//   ptr_load_enable  -> instr_ptr load_enable  (combinational)
//   ptr_load_val     -> instr_ptr load_val     (combinational)
//   running          registered, state is RUN
//   halted           registered, state is HALT
//   err              registered, state is ERR
//   err_code         registered, 0 none / 1 stack overflow / 2 stack underflow
//   stack_level      registered count of valid stack entries
// -----------------------------------------------------------------------------
module instr_ptr_ctrl #(
   parameter int WIDTH       = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             start,
   input  logic [WIDTH-1:0]                 start_addr,
   input  logic                             stall,
   input  logic                             halt_req,
   input  logic                             jump_req,
   input  logic                             jump_cond,
   input  logic                             call_req,
   input  logic                             ret_req,
   input  logic [WIDTH-1:0]                 jump_addr,
   input  logic [WIDTH-1:0]                 ptr_in,
   output logic                             ptr_enable,
   output logic                             ptr_load_enable,
   output logic [WIDTH-1:0]                 ptr_load_val,
   output logic                             running,
   output logic                             halted,
   output logic                             err,
   output logic [1:0]                       err_code,
   output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level
);

   localparam int LW = $clog2(STACK_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   localparam logic [1:0]       ERR_NONE = 2'd0;
   localparam logic [1:0]       ERR_OVF  = 2'd1;
   localparam logic [1:0]       ERR_UNF  = 2'd2;
   localparam logic [LW-1:0]    LVL_ZERO = LW'(0);
   localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
   localparam logic [LW-1:0]    LVL_FULL = LW'(STACK_DEPTH);
   localparam logic [WIDTH-1:0] ADDR_ONE = WIDTH'(1);

   state_t            state_r;
   state_t            state_next_s;
   logic [LW-1:0]     level_r;
   logic [LW-1:0]     level_next_s;
   logic [1:0]        err_code_r;
   logic [1:0]        err_code_next_s;
   logic              running_r;
   logic              halted_r;
   logic              err_r;
   logic [WIDTH-1:0]  stack_r [STACK_DEPTH];

   logic              push_s;
   logic              pop_s;
   logic              clear_s;
   logic              enable_s;
   logic              load_enable_s;
   logic [WIDTH-1:0]  load_val_s;
   logic [WIDTH-1:0]  top_s;
   logic [WIDTH-1:0]  ret_addr_s;

   // Return address for a call: the instruction after the call, wrapping silently.
   assign ret_addr_s = ptr_in + ADDR_ONE;

   // Top-of-stack read: the most recent push lives at index level-1.
   always_comb begin
      top_s = '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         top_s = (level_r == LW'(i + 1)) ? stack_r[i] : top_s;
      end
   end

   // Next-state and pointer-control decode; one action per RUN cycle.
   always_comb begin
      state_next_s    = state_r;
      err_code_next_s = err_code_r;
      enable_s        = 1'b0;
      load_enable_s   = 1'b0;
      load_val_s      = '0;
      push_s          = 1'b0;
      pop_s           = 1'b0;
      clear_s         = 1'b0;

      case (state_r)
         ST_IDLE, ST_HALT, ST_ERR: begin
            if (start) begin
               enable_s        = 1'b1;
               load_enable_s   = 1'b1;
               load_val_s      = start_addr;
               clear_s         = 1'b1;
               err_code_next_s = ERR_NONE;
               state_next_s    = ST_RUN;
            end else begin
               state_next_s    = state_r;
            end
         end

         ST_RUN: begin
            if (stall) begin
               // Pointer holds; every other request is ignored this cycle.
               enable_s = 1'b0;
            end else if (halt_req) begin
               // Pointer stays on the halt instruction.
               state_next_s = ST_HALT;
            end else if (ret_req) begin
               if (level_r != LVL_ZERO) begin
                  pop_s         = 1'b1;
                  enable_s      = 1'b1;
                  load_enable_s = 1'b1;
                  load_val_s    = top_s;
               end else begin
                  err_code_next_s = ERR_UNF;
                  state_next_s    = ST_ERR;
               end
            end else if (call_req) begin
               if (level_r < LVL_FULL) begin
                  push_s        = 1'b1;
                  enable_s      = 1'b1;
                  load_enable_s = 1'b1;
                  load_val_s    = jump_addr;
               end else begin
                  err_code_next_s = ERR_OVF;
                  state_next_s    = ST_ERR;
               end
            end else if (jump_req && jump_cond) begin
               enable_s      = 1'b1;
               load_enable_s = 1'b1;
               load_val_s    = jump_addr;
            end else begin
               // Plain increment, also covers a not-taken jump.
               enable_s = 1'b1;
            end
         end

         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Stack occupancy update: clear on start, then push/pop move by one.
   always_comb begin
      if (clear_s) begin
         level_next_s = LVL_ZERO;
      end else if (push_s) begin
         level_next_s = level_r + LVL_ONE;
      end else if (pop_s) begin
         level_next_s = level_r - LVL_ONE;
      end else begin
         level_next_s = level_r;
      end
   end

   // State, occupancy and status registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         level_r    <= LVL_ZERO;
         err_code_r <= ERR_NONE;
         running_r  <= 1'b0;
         halted_r   <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         level_r    <= level_next_s;
         err_code_r <= err_code_next_s;
         running_r  <= (state_next_s == ST_RUN);
         halted_r   <= (state_next_s == ST_HALT);
         err_r      <= (state_next_s == ST_ERR);
      end
   end

   // Call-stack storage; entries are zeroed on reset and on start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_r[i] <= '0;
         end
      end else if (clear_s) begin
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push_s && (level_r == LW'(i))) begin
               stack_r[i] <= ret_addr_s;
            end
         end
      end
   end

   assign ptr_enable      = enable_s;
   assign ptr_load_enable = load_enable_s;
   assign ptr_load_val    = load_val_s;
   assign running         = running_r;
   assign halted          = halted_r;
   assign err             = err_r;
   assign err_code        = err_code_r;
   assign stack_level     = level_r;

endmodule

// File: tb/tb_instr_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_instr_ptr_ctrl
//
// Directed bench for instr_ptr_ctrl. A small instr_ptr model closes the loop on
// ptr_in. Stimulus pushes expected values (tagged with the cycle they belong
// to) into a queue; a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_instr_ptr_ctrl;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH + 1);

   localparam int S_PTR  = 0;
   localparam int S_EN   = 1;
   localparam int S_LD   = 2;
   localparam int S_LVAL = 3;
   localparam int S_RUN  = 4;
   localparam int S_HALT = 5;
   localparam int S_ERR  = 6;
   localparam int S_CODE = 7;
   localparam int S_LVL  = 8;

   logic             clk;
   logic             reset_n;
   logic             start;
   logic [WIDTH-1:0] start_addr;
   logic             stall;
   logic             halt_req;
   logic             jump_req;
   logic             jump_cond;
   logic             call_req;
   logic             ret_req;
   logic [WIDTH-1:0] jump_addr;
   logic [WIDTH-1:0] ptr_q;
   logic             ptr_enable;
   logic             ptr_load_enable;
   logic [WIDTH-1:0] ptr_load_val;
   logic             running;
   logic             halted;
   logic             err;
   logic [1:0]       err_code;
   logic [LW-1:0]    stack_level;

   typedef struct {
      int    cyc;
      int    sel;
      int    val;
      string name;
   } item_t;

   item_t q[$];
   int    cyc   = 0;
   int    total = 0;
   int    bad   = 0;
   bit    done  = 1'b0;

   instr_ptr_ctrl #(.WIDTH(WIDTH), .STACK_DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .start_addr      (start_addr),
      .stall           (stall),
      .halt_req        (halt_req),
      .jump_req        (jump_req),
      .jump_cond       (jump_cond),
      .call_req        (call_req),
      .ret_req         (ret_req),
      .jump_addr       (jump_addr),
      .ptr_in          (ptr_q),
      .ptr_enable      (ptr_enable),
      .ptr_load_enable (ptr_load_enable),
      .ptr_load_val    (ptr_load_val),
      .running         (running),
      .halted          (halted),
      .err             (err),
      .err_code        (err_code),
      .stack_level     (stack_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // instr_ptr model: load has priority, otherwise increment, both gated by enable.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) ptr_q <= '0;
      else if (ptr_enable) ptr_q <= ptr_load_enable ? ptr_load_val : ptr_q + 8'd1;
   end

   function automatic logic [31:0] actual(input int sel);
      case (sel)
         S_PTR:   return {24'd0, ptr_q};
         S_EN:    return {31'd0, ptr_enable};
         S_LD:    return {31'd0, ptr_load_enable};
         S_LVAL:  return {24'd0, ptr_load_val};
         S_RUN:   return {31'd0, running};
         S_HALT:  return {31'd0, halted};
         S_ERR:   return {31'd0, err};
         S_CODE:  return {30'd0, err_code};
         S_LVL:   return {29'd0, stack_level};
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Monitor: compare every expectation due in the current cycle, then report.
   always @(negedge clk) begin
      logic [31:0] act;
      item_t       it;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         it    = q.pop_front();
         act   = actual(it.sel);
         total = total + 1;
         if (act !== 32'(it.val)) begin
            bad = bad + 1;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", it.name, it.cyc, act, it.val);
         end
      end
      if (done) begin
         if (q.size() > 0) begin
            total = total + q.size();
            bad   = bad + q.size();
            $display("FAIL pending: %0d expectations never checked", q.size());
         end
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic want(input int sel, input int val, input string nm);
      item_t it;
      it.cyc  = cyc;
      it.sel  = sel;
      it.val  = val;
      it.name = nm;
      q.push_back(it);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      start    = 1'b0;
      stall    = 1'b0;
      halt_req = 1'b0;
      jump_req = 1'b0;
      jump_cond = 1'b0;
      call_req = 1'b0;
      ret_req  = 1'b0;
   endtask

   // Move the pointer to addr with a taken jump.
   task automatic go(input logic [7:0] addr);
      jump_req  = 1'b1;
      jump_cond = 1'b1;
      jump_addr = addr;
      tick();
      clear_req();
   endtask

   initial begin
      reset_n    = 1'b1;
      start_addr = 8'h00;
      jump_addr  = 8'h00;
      clear_req();
      #2 reset_n = 1'b0;
      tick();
      tick();

      // Reset state
      want(S_RUN, 0, "rst_running");
      want(S_HALT, 0, "rst_halted");
      want(S_ERR, 0, "rst_err");
      want(S_CODE, 0, "rst_err_code");
      want(S_LVL, 0, "rst_level");
      want(S_EN, 0, "rst_enable");
      reset_n = 1'b1;
      tick();
      want(S_EN, 0, "idle_enable");
      tick();

      // Start at 0x10 then free-run
      start = 1'b1; start_addr = 8'h10;
      want(S_EN, 1, "start_en"); want(S_LD, 1, "start_ld"); want(S_LVAL, 8'h10, "start_lval");
      tick(); clear_req();
      want(S_PTR, 8'h10, "inc0"); want(S_LD, 0, "inc_ld"); tick();
      want(S_PTR, 8'h11, "inc1"); tick();
      want(S_PTR, 8'h12, "inc2"); tick();
      want(S_PTR, 8'h13, "inc3"); want(S_RUN, 1, "running"); want(S_HALT, 0, "not_halted");
      tick();

      // start while running is ignored
      start = 1'b1; start_addr = 8'hA0;
      want(S_LD, 0, "start_in_run_ld");
      tick(); clear_req();
      want(S_PTR, 8'h15, "start_in_run_ptr");

      // Jump taken / not taken at 0x20
      go(8'h20);
      want(S_PTR, 8'h20, "at_20");
      jump_req = 1'b1; jump_cond = 1'b1; jump_addr = 8'h40;
      want(S_LD, 1, "jmp_ld"); want(S_LVAL, 8'h40, "jmp_lval"); want(S_EN, 1, "jmp_en");
      tick(); clear_req();
      want(S_PTR, 8'h40, "jmp_ptr"); tick();
      want(S_PTR, 8'h41, "jmp_next");
      go(8'h20);
      jump_req = 1'b1; jump_cond = 1'b0; jump_addr = 8'h40;
      want(S_LD, 0, "njmp_ld"); want(S_EN, 1, "njmp_en");
      tick(); clear_req();
      want(S_PTR, 8'h21, "njmp_ptr");

      // Call / return
      go(8'h30);
      call_req = 1'b1; jump_addr = 8'h50;
      want(S_LD, 1, "call_ld"); want(S_LVAL, 8'h50, "call_lval");
      tick(); clear_req();
      want(S_PTR, 8'h50, "call_ptr"); want(S_LVL, 1, "call_level"); tick();
      want(S_PTR, 8'h51, "call_inc1"); tick();
      want(S_PTR, 8'h52, "call_inc2");
      ret_req = 1'b1;
      want(S_LD, 1, "ret_ld"); want(S_LVAL, 8'h31, "ret_lval");
      tick(); clear_req();
      want(S_PTR, 8'h31, "ret_ptr"); want(S_LVL, 0, "ret_level");

      // Nested calls up to overflow
      for (int i = 0; i < DEPTH; i++) begin
         call_req = 1'b1; jump_addr = 8'h60 + 8'(i);
         want(S_EN, 1, "nest_en");
         tick();
      end
      call_req = 1'b1; jump_addr = 8'h70;
      want(S_EN, 0, "ovf_en"); want(S_LD, 0, "ovf_ld"); want(S_LVL, DEPTH, "ovf_level_pre");
      tick(); clear_req();
      want(S_EN, 0, "err_hold_en"); tick();
      want(S_ERR, 1, "ovf_err"); want(S_CODE, 1, "ovf_code"); want(S_LVL, DEPTH, "ovf_level");
      want(S_RUN, 0, "ovf_not_running"); want(S_PTR, 8'h63, "ovf_ptr"); tick();
      want(S_ERR, 1, "ovf_sticky");

      // Recover, then underflow
      start = 1'b1; start_addr = 8'h70;
      tick(); clear_req();
      want(S_LVL, 0, "recover_level"); want(S_ERR, 0, "recover_err");
      ret_req = 1'b1;
      want(S_EN, 0, "unf_en");
      tick(); clear_req();
      tick();
      want(S_ERR, 1, "unf_err"); want(S_CODE, 2, "unf_code"); want(S_LVL, 0, "unf_level");

      // Recover at 0x18, stall together with a jump
      start = 1'b1; start_addr = 8'h18;
      tick(); clear_req();
      for (int i = 0; i < 3; i++) begin
         stall = 1'b1; jump_req = 1'b1; jump_cond = 1'b1; jump_addr = 8'h28;
         want(S_PTR, 8'h18, "stall_ptr"); want(S_EN, 0, "stall_en");
         if (i == 1) begin
            want(S_ERR, 0, "recover2_err"); want(S_CODE, 0, "recover2_code"); want(S_RUN, 1, "recover2_run");
         end
         tick();
      end
      stall = 1'b0;
      want(S_LD, 1, "unstall_ld"); want(S_LVAL, 8'h28, "unstall_lval");
      tick(); clear_req();
      want(S_PTR, 8'h28, "unstall_ptr");

      // Halt freezes the pointer
      halt_req = 1'b1; jump_req = 1'b1; jump_cond = 1'b1; jump_addr = 8'h99;
      want(S_EN, 0, "halt_en");
      tick(); clear_req();
      want(S_PTR, 8'h28, "halt_ptr"); tick();
      want(S_HALT, 1, "halted"); want(S_RUN, 0, "halt_not_running"); want(S_PTR, 8'h28, "halt_frozen");

      // Wrap from 0xFF
      start = 1'b1; start_addr = 8'hFF;
      tick(); clear_req();
      want(S_PTR, 8'hFF, "wrap_ff"); want(S_EN, 1, "wrap_en"); tick();
      want(S_PTR, 8'h00, "wrap_00");
      call_req = 1'b1; jump_addr = 8'h80;
      tick(); clear_req();
      want(S_LVL, 1, "pre_rst_level"); want(S_PTR, 8'h80, "pre_rst_ptr");
      tick();

      // Reset mid-RUN
      reset_n = 1'b0;
      #1;
      want(S_EN, 0, "rst_mid_en"); want(S_RUN, 0, "rst_mid_running"); want(S_LVL, 0, "rst_mid_level");
      tick();
      reset_n = 1'b1;
      want(S_EN, 0, "post_rst_en"); want(S_RUN, 0, "post_rst_running"); want(S_LVL, 0, "post_rst_level");
      tick();
      tick();
      done = 1'b1;
   end

endmodule
